// File: rtl/sfifo_pkg.sv
// Shared sizing for the 32-bit-in / 64-bit-out synchronous FIFO.
// Optional error flags are enabled with the SFIFO_ERR_FLAG_EN macro.
package sfifo_pkg;

  localparam int WR_WIDTH  = 32;
  localparam int RD_WIDTH  = 2 * WR_WIDTH;
  localparam int WR_DEPTH  = 512;
  localparam int RD_DEPTH  = WR_DEPTH / 2;
  localparam int WR_AW     = $clog2(WR_DEPTH);
  localparam int RD_AW     = WR_AW - 1;
  localparam int WR_LVL_W  = WR_AW + 1;
  localparam int RD_LVL_W  = WR_AW;
  localparam int AF_TH_DEF = 496;
  localparam int AE_TH_DEF = 4;

  typedef logic [WR_WIDTH-1:0] wr_word_t;
  typedef logic [RD_WIDTH-1:0] rd_word_t;
  typedef logic [WR_LVL_W-1:0] wr_lvl_t;
  typedef logic [RD_LVL_W-1:0] rd_lvl_t;

  // Bit order matches {write accepted, read accepted}.
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_RD   = 2'b01,
    OP_WR   = 2'b10,
    OP_RW   = 2'b11
  } op_e;

endpackage

// File: rtl/sfifo_32i_64o_512_if.sv
// Producer/consumer bus of the width-converting FIFO.
// The sticky error flags exist only when SFIFO_ERR_FLAG_EN is defined.
interface sfifo_32i_64o_512_if;
  import sfifo_pkg::*;

  logic     wr_en;
  wr_word_t wr_data;
  logic     wr_full;
  wr_lvl_t  wr_water_level;
  logic     almost_full;
  logic     rd_en;
  rd_word_t rd_data;
  logic     rd_empty;
  rd_lvl_t  rd_water_level;
  logic     almost_empty;
`ifdef SFIFO_ERR_FLAG_EN
  logic     wr_overflow;
  logic     rd_underflow;
`endif

  modport master (
    output wr_en, wr_data, rd_en,
    input  wr_full, wr_water_level, almost_full,
    input  rd_data, rd_empty, rd_water_level, almost_empty
`ifdef SFIFO_ERR_FLAG_EN
    , input wr_overflow, rd_underflow
`endif
  );

  modport slave (
    input  wr_en, wr_data, rd_en,
    output wr_full, wr_water_level, almost_full,
    output rd_data, rd_empty, rd_water_level, almost_empty
`ifdef SFIFO_ERR_FLAG_EN
    , output wr_overflow, rd_underflow
`endif
  );

endinterface

// File: rtl/sfifo_sdp_ram.sv
// Simple dual-port 256x64 RAM with independent low/high half write enables
// and a registered, resettable read port.
module sfifo_sdp_ram
  import sfifo_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wr_lo_en_i,
  input  logic             wr_hi_en_i,
  input  logic [RD_AW-1:0] wr_addr_i,
  input  wr_word_t         wr_data_i,
  input  logic             rd_en_i,
  input  logic [RD_AW-1:0] rd_addr_i,
  output rd_word_t         rd_data_o
);

  wr_word_t mem_lo [RD_DEPTH];
  wr_word_t mem_hi [RD_DEPTH];
  rd_word_t rd_data_q;

  // Storage is never reset; only the output register is.
  always_ff @(posedge clk_i) begin
    if (wr_lo_en_i) mem_lo[wr_addr_i] <= wr_data_i;
    if (wr_hi_en_i) mem_hi[wr_addr_i] <= wr_data_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_data_q <= '0;
    end else if (rd_en_i) begin
      rd_data_q <= {mem_hi[rd_addr_i], mem_lo[rd_addr_i]};
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/sfifo_32i_64o_512.sv
// Single-clock FIFO packing pairs of 32-bit writes into 64-bit reads.
// Define SFIFO_ERR_FLAG_EN to add sticky wr_overflow / rd_underflow flags.
module sfifo_32i_64o_512
  import sfifo_pkg::*;
#(
  parameter int AF_TH = AF_TH_DEF,
  parameter int AE_TH = AE_TH_DEF
) (
  input logic               clk,
  input logic               rst,
  sfifo_32i_64o_512_if.slave bus
);

  localparam wr_lvl_t AfThL = wr_lvl_t'(AF_TH);
  localparam rd_lvl_t AeThL = rd_lvl_t'(AE_TH);
  localparam wr_lvl_t FullL = wr_lvl_t'(WR_DEPTH);

  logic [WR_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [RD_AW-1:0] rd_ptr_q, rd_ptr_d;
  wr_lvl_t          level_q, level_d;
  rd_lvl_t          rd_level;
  logic             full, empty, wr_acc, rd_acc;
  op_e              op;

  // Only whole 64-bit words count as readable; an odd leftover waits for its partner.
  assign rd_level = level_q[WR_LVL_W-1:1];
  assign full     = (level_q == FullL);
  assign empty    = (rd_level == '0);
  assign wr_acc   = bus.wr_en && !full;
  assign rd_acc   = bus.rd_en && !empty;
  assign op       = op_e'({wr_acc, rd_acc});

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + WR_AW'(1);
    if (rd_acc) rd_ptr_d = rd_ptr_q + RD_AW'(1);
    case (op)
      OP_WR:   level_d = level_q + wr_lvl_t'(1);
      OP_RD:   level_d = level_q - wr_lvl_t'(2);
      OP_RW:   level_d = level_q - wr_lvl_t'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Even write pointer fills the low half, odd fills the high half of the same row.
  sfifo_sdp_ram u_ram (
    .clk_i      (clk),
    .rst_i      (rst),
    .wr_lo_en_i (wr_acc & ~wr_ptr_q[0]),
    .wr_hi_en_i (wr_acc & wr_ptr_q[0]),
    .wr_addr_i  (wr_ptr_q[WR_AW-1:1]),
    .wr_data_i  (bus.wr_data),
    .rd_en_i    (rd_acc),
    .rd_addr_i  (rd_ptr_q),
    .rd_data_o  (bus.rd_data)
  );

  assign bus.wr_full        = full;
  assign bus.wr_water_level = level_q;
  assign bus.almost_full    = (level_q >= AfThL);
  assign bus.rd_empty       = empty;
  assign bus.rd_water_level = rd_level;
  assign bus.almost_empty   = (rd_level <= AeThL);

`ifdef SFIFO_ERR_FLAG_EN
  logic wr_ovf_q, rd_udf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ovf_q <= 1'b0;
      rd_udf_q <= 1'b0;
    end else begin
      if (bus.wr_en && full)  wr_ovf_q <= 1'b1;
      if (bus.rd_en && empty) rd_udf_q <= 1'b1;
    end
  end

  assign bus.wr_overflow  = wr_ovf_q;
  assign bus.rd_underflow = rd_udf_q;
`endif

endmodule

// File: tb/tb_sfifo_32i_64o_512.sv
// Self-checking bench: queue-based reference model compared every cycle,
// plus directed literal checks from the test plan and randomized traffic.
module tb_sfifo_32i_64o_512;

  logic clk;
  logic rst;
  sfifo_32i_64o_512_if busIf ();

  sfifo_32i_64o_512 dut (
    .clk (clk),
    .rst (rst),
    .bus (busIf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit checkOn = 1'b0;

  logic [31:0] modelQ[$];
  logic [63:0] expData = '0;
  bit          expOvf = 1'b0;
  bit          expUdf = 1'b0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of 32-bit words; pre-edge size decides acceptance.
  always @(posedge clk) begin
    if (rst) begin
      modelQ.delete();
      expData = '0;
      expOvf  = 1'b0;
      expUdf  = 1'b0;
    end else begin
      automatic bit isFull  = (modelQ.size() == 512);
      automatic bit isEmpty = (modelQ.size() < 2);
      automatic bit rdOk    = busIf.rd_en && !isEmpty;
      automatic bit wrOk    = busIf.wr_en && !isFull;
      if (busIf.wr_en && isFull)  expOvf = 1'b1;
      if (busIf.rd_en && isEmpty) expUdf = 1'b1;
      if (rdOk) begin
        expData = {modelQ[1], modelQ[0]};
        void'(modelQ.pop_front());
        void'(modelQ.pop_front());
      end
      if (wrOk) modelQ.push_back(busIf.wr_data);
    end
  end

  always @(negedge clk) begin
    if (checkOn) begin
      checkOutput("wr_water_level", 64'(busIf.wr_water_level), 64'(modelQ.size()));
      checkOutput("rd_water_level", 64'(busIf.rd_water_level), 64'(modelQ.size() / 2));
      checkOutput("rd_empty", 64'(busIf.rd_empty), 64'(modelQ.size() < 2));
      checkOutput("wr_full", 64'(busIf.wr_full), 64'(modelQ.size() == 512));
      checkOutput("almost_full", 64'(busIf.almost_full), 64'(modelQ.size() >= 496));
      checkOutput("almost_empty", 64'(busIf.almost_empty), 64'((modelQ.size() / 2) <= 4));
      checkOutput("rd_data", busIf.rd_data, expData);
`ifdef SFIFO_ERR_FLAG_EN
      checkOutput("wr_overflow", 64'(busIf.wr_overflow), 64'(expOvf));
      checkOutput("rd_underflow", 64'(busIf.rd_underflow), 64'(expUdf));
`endif
    end
  end

  // Drives one cycle of inputs at the falling edge and returns at the next one.
  task automatic applyStimulus(input logic w, input logic [31:0] d, input logic r);
    busIf.wr_en   = w;
    busIf.wr_data = d;
    busIf.rd_en   = r;
    @(negedge clk);
  endtask

  logic [31:0] lastLo, lastHi, word;
  int          wrPct[6] = '{70, 30, 90, 50, 95, 10};
  int          rdPct[6] = '{30, 70, 90, 50, 10, 95};

  initial begin
    rst           = 1'b1;
    busIf.wr_en   = 1'b0;
    busIf.wr_data = '0;
    busIf.rd_en   = 1'b0;
    @(negedge clk);
    checkOn = 1'b1;
    repeat (19) @(negedge clk);

    checkOutput("reset rd_empty", 64'(busIf.rd_empty), 64'd1);
    checkOutput("reset wr_full", 64'(busIf.wr_full), 64'd0);
    checkOutput("reset wr_level", 64'(busIf.wr_water_level), 64'd0);
    checkOutput("reset rd_level", 64'(busIf.rd_water_level), 64'd0);
    checkOutput("reset rd_data", busIf.rd_data, 64'd0);
    checkOutput("reset almost_empty", 64'(busIf.almost_empty), 64'd1);
    checkOutput("reset almost_full", 64'(busIf.almost_full), 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 256; i++) applyStimulus(1'b1, 32'(1024 + i), 1'b0);
    checkOutput("fill256 wr_level", 64'(busIf.wr_water_level), 64'd256);
    checkOutput("fill256 rd_level", 64'(busIf.rd_water_level), 64'd128);
    checkOutput("fill256 almost_empty", 64'(busIf.almost_empty), 64'd0);
    checkOutput("fill256 almost_full", 64'(busIf.almost_full), 64'd0);

    for (int i = 0; i < 513; i++) begin
      applyStimulus(1'b0, '0, 1'b1);
      if (i == 0)   checkOutput("first read", busIf.rd_data, 64'h00000401_00000400);
      if (i == 127) checkOutput("128th read", busIf.rd_data, 64'h000004FF_000004FE);
      if (i == 127) checkOutput("drained rd_empty", 64'(busIf.rd_empty), 64'd1);
    end
    checkOutput("underflow hold rd_data", busIf.rd_data, 64'h000004FF_000004FE);
    checkOutput("underflow wr_level", 64'(busIf.wr_water_level), 64'd0);
    checkOutput("underflow rd_level", 64'(busIf.rd_water_level), 64'd0);
`ifdef SFIFO_ERR_FLAG_EN
    checkOutput("rd_underflow set", 64'(busIf.rd_underflow), 64'd1);
`endif

    lastLo = '0;
    lastHi = '0;
    for (int i = 0; i < 512; i++) begin
      word = $urandom;
      if (i == 510) lastLo = word;
      if (i == 511) lastHi = word;
      applyStimulus(1'b1, word, 1'b0);
    end
    applyStimulus(1'b1, 32'hDEADBEEF, 1'b0);
    checkOutput("full wr_full", 64'(busIf.wr_full), 64'd1);
    checkOutput("full wr_level", 64'(busIf.wr_water_level), 64'd512);
    checkOutput("full almost_full", 64'(busIf.almost_full), 64'd1);
`ifdef SFIFO_ERR_FLAG_EN
    checkOutput("wr_overflow set", 64'(busIf.wr_overflow), 64'd1);
`endif
    for (int i = 0; i < 257; i++) applyStimulus(1'b0, '0, 1'b1);
    checkOutput("full last pair", busIf.rd_data, {lastHi, lastLo});
    checkOutput("full drained level", 64'(busIf.wr_water_level), 64'd0);

    applyStimulus(1'b1, 32'hAAAA0001, 1'b0);
    applyStimulus(1'b1, 32'hBBBB0002, 1'b0);
    applyStimulus(1'b1, 32'hCCCC0003, 1'b0);
    checkOutput("odd rd_level", 64'(busIf.rd_water_level), 64'd1);
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("odd read BA", busIf.rd_data, 64'hBBBB0002_AAAA0001);
    checkOutput("odd rd_empty", 64'(busIf.rd_empty), 64'd1);
    checkOutput("odd wr_level", 64'(busIf.wr_water_level), 64'd1);
    applyStimulus(1'b1, 32'hDDDD0004, 1'b0);
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("odd read DC", busIf.rd_data, 64'hDDDD0004_CCCC0003);
    checkOutput("odd final level", 64'(busIf.wr_water_level), 64'd0);

    for (int i = 0; i < 100; i++) applyStimulus(1'b1, $urandom, 1'b0);
    checkOutput("simul start level", 64'(busIf.wr_water_level), 64'd100);
    for (int i = 0; i < 50; i++) begin
      applyStimulus(1'b1, $urandom, 1'b1);
      checkOutput("simul level", 64'(busIf.wr_water_level), 64'(99 - i));
    end
    checkOutput("simul end level", 64'(busIf.wr_water_level), 64'd50);
    repeat (5) applyStimulus(1'b1, $urandom, 1'b1);
    rst = 1'b1;
    applyStimulus(1'b1, $urandom, 1'b1);
    checkOutput("midrst wr_level", 64'(busIf.wr_water_level), 64'd0);
    checkOutput("midrst rd_level", 64'(busIf.rd_water_level), 64'd0);
    checkOutput("midrst rd_empty", 64'(busIf.rd_empty), 64'd1);
    checkOutput("midrst rd_data", busIf.rd_data, 64'd0);
    rst = 1'b0;

    // Biased random phases push the FIFO toward full, empty and steady state.
    for (int p = 0; p < 6; p++) begin
      for (int c = 0; c < 500; c++) begin
        applyStimulus(($urandom_range(99) < 32'(wrPct[p])), $urandom,
                      ($urandom_range(99) < 32'(rdPct[p])));
      end
    end
    applyStimulus(1'b0, '0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
